// File: rtl/mem_port_arb_if.sv
// ---------------------------------------------------------------------------
// mem_port_arb_if
// Bundles the three handshake channels seen by mem_port_arb:
//   I port  : ireq* (request in), irsp* (response out)
//   D port  : dreq* (request in, with write fields), drsp* (response out)
//   M port  : mreq* (shared request out), mrsp* (shared response in)
// Modports:
//   slave  - the arbiter itself (consumes I/D requests, drives the M port)
//   master - the surrounding system (drives I/D requests, serves the M port)
// ---------------------------------------------------------------------------
interface mem_port_arb_if;
    logic        ireqvalid_i;
    logic        ireqready_o;
    logic [1:0]  ireqhpl_i;
    logic [31:0] ireqaddr_i;
    logic        irspvalid_o;
    logic        irspready_i;
    logic        irsprerr_o;
    logic [31:0] irspdata_o;

    logic        dreqvalid_i;
    logic        dreqready_o;
    logic [1:0]  dreqhpl_i;
    logic [31:0] dreqaddr_i;
    logic        dreqwen_i;
    logic [3:0]  dreqbe_i;
    logic [31:0] dreqdata_i;
    logic        drspvalid_o;
    logic        drspready_i;
    logic        drsprerr_o;
    logic        drspwerr_o;
    logic [31:0] drspdata_o;

    logic        mreqvalid_o;
    logic        mreqready_i;
    logic [1:0]  mreqhpl_o;
    logic [31:0] mreqaddr_o;
    logic        mreqwen_o;
    logic [3:0]  mreqbe_o;
    logic [31:0] mreqdata_o;
    logic        mrspvalid_i;
    logic        mrspready_o;
    logic        mrsprerr_i;
    logic        mrspwerr_i;
    logic [31:0] mrspdata_i;

    logic        spurious_o;

    modport slave (
        input  ireqvalid_i, ireqhpl_i, ireqaddr_i, irspready_i,
        output ireqready_o, irspvalid_o, irsprerr_o, irspdata_o,
        input  dreqvalid_i, dreqhpl_i, dreqaddr_i, dreqwen_i, dreqbe_i,
               dreqdata_i, drspready_i,
        output dreqready_o, drspvalid_o, drsprerr_o, drspwerr_o, drspdata_o,
        output mreqvalid_o, mreqhpl_o, mreqaddr_o, mreqwen_o, mreqbe_o,
               mreqdata_o, mrspready_o,
        input  mreqready_i, mrspvalid_i, mrsprerr_i, mrspwerr_i, mrspdata_i,
        output spurious_o
    );

    modport master (
        output ireqvalid_i, ireqhpl_i, ireqaddr_i, irspready_i,
        input  ireqready_o, irspvalid_o, irsprerr_o, irspdata_o,
        output dreqvalid_i, dreqhpl_i, dreqaddr_i, dreqwen_i, dreqbe_i,
               dreqdata_i, drspready_i,
        input  dreqready_o, drspvalid_o, drsprerr_o, drspwerr_o, drspdata_o,
        input  mreqvalid_o, mreqhpl_o, mreqaddr_o, mreqwen_o, mreqbe_o,
               mreqdata_o, mrspready_o,
        output mreqready_i, mrspvalid_i, mrsprerr_i, mrspwerr_i, mrspdata_i,
        input  spurious_o
    );
endinterface

// File: rtl/mem_port_arb.sv
// ---------------------------------------------------------------------------
// mem_port_arb
// Merges an instruction (I) and a data (D) request channel onto one shared
// memory (M) port with zero added latency, and steers in-order M responses
// back to the requester recorded in a small ordering FIFO.
//
// Ports:
//   clk_i     - clock
//   reset_i   - asynchronous, active-high reset (abandons outstanding work)
//   clk_en_i  - state-update enable; combinational paths stay live when low
//   bus       - mem_port_arb_if.slave: I/D request+response, M request+response,
//               spurious_o pulse for a response with nothing outstanding
//
// Parameter:
//   C_OTX     - log2 of the number of outstanding transactions (>= 1)
//
// Build option:
//   MEM_PORT_ARB_RR_EN - when defined, contested grants alternate round-robin;
//                        otherwise D has fixed priority over I.
// ---------------------------------------------------------------------------
module mem_port_arb #(
    parameter int C_OTX = 2
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           clk_en_i,
    mem_port_arb_if.slave  bus
);
    localparam int DEPTH = 1 << C_OTX;

    // Ordering FIFO: one bit per outstanding transaction (0 = I, 1 = D).
    // Pointers carry one extra wrap bit to separate full from empty.
    logic [C_OTX:0] wptr;
    logic [C_OTX:0] rptr;
    logic           fifo_mem [DEPTH];

    logic locked;     // a presented request was not yet accepted
    logic lock_d;     // owner of the lock (1 = D)
    logic spurious;

`ifdef MEM_PORT_ARB_RR_EN
    logic last_d;     // source of the most recent acceptance (1 = D)
`endif

    logic full;
    logic empty;
    logic gnt_d;
    logic req_open;
    logic req_valid;
    logic accept;
    logic head_d;
    logic rsp_ready;
    logic pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[C_OTX] != rptr[C_OTX]) &&
                   (wptr[C_OTX-1:0] == rptr[C_OTX-1:0]);

    // Grant selection; a locked owner keeps the port until its acceptance.
    always_comb begin
        gnt_d = bus.dreqvalid_i;
        if (locked) begin
            gnt_d = lock_d;
        end else if (bus.ireqvalid_i && bus.dreqvalid_i) begin
`ifdef MEM_PORT_ARB_RR_EN
            gnt_d = ~last_d;
`else
            gnt_d = 1'b1;
`endif
        end
    end

    // Full is taken from registered pointers only, so a response popping in
    // the same cycle never opens the request side (no rsp->req comb path).
    assign req_open  = !reset_i && !full;
    assign req_valid = req_open && (gnt_d ? bus.dreqvalid_i : bus.ireqvalid_i);
    assign accept    = req_valid && bus.mreqready_i && clk_en_i;

    assign bus.mreqvalid_o = req_valid;
    assign bus.ireqready_o = req_open && !gnt_d && bus.mreqready_i;
    assign bus.dreqready_o = req_open &&  gnt_d && bus.mreqready_i;

    assign bus.mreqhpl_o  = gnt_d ? bus.dreqhpl_i  : bus.ireqhpl_i;
    assign bus.mreqaddr_o = gnt_d ? bus.dreqaddr_i : bus.ireqaddr_i;
    assign bus.mreqwen_o  = gnt_d ? bus.dreqwen_i  : 1'b0;
    assign bus.mreqbe_o   = gnt_d ? bus.dreqbe_i   : 4'hF;
    assign bus.mreqdata_o = gnt_d ? bus.dreqdata_i : 32'h0;

    // Response steering by FIFO head; with nothing outstanding the response
    // is swallowed (ready forced high) and flagged as spurious.
    assign head_d    = fifo_mem[rptr[C_OTX-1:0]];
    assign rsp_ready = empty ? 1'b1 : (head_d ? bus.drspready_i : bus.irspready_i);
    assign pop       = bus.mrspvalid_i && !empty && rsp_ready && clk_en_i;

    assign bus.mrspready_o = rsp_ready;
    assign bus.irspvalid_o = bus.mrspvalid_i && !empty && !head_d;
    assign bus.drspvalid_o = bus.mrspvalid_i && !empty &&  head_d;
    assign bus.irsprerr_o  = bus.mrsprerr_i;
    assign bus.irspdata_o  = bus.mrspdata_i;
    assign bus.drsprerr_o  = bus.mrsprerr_i;
    assign bus.drspwerr_o  = bus.mrspwerr_i;
    assign bus.drspdata_o  = bus.mrspdata_i;
    assign bus.spurious_o  = spurious;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr     <= '0;
            rptr     <= '0;
            locked   <= 1'b0;
            lock_d   <= 1'b0;
            spurious <= 1'b0;
`ifdef MEM_PORT_ARB_RR_EN
            last_d   <= 1'b0;
`endif
        end else if (clk_en_i) begin
            if (accept) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            locked   <= req_valid && !bus.mreqready_i;
            lock_d   <= gnt_d;
            spurious <= bus.mrspvalid_i && empty;
`ifdef MEM_PORT_ARB_RR_EN
            if (accept) begin
                last_d <= gnt_d;
            end
`endif
        end
    end

    // FIFO storage holds data only; validity is defined by the pointers.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            fifo_mem[wptr[C_OTX-1:0]] <= gnt_d;
        end
    end
endmodule
